// File: rtl/vector_sweep_checker.sv
// ---------------------------------------------------------------------------
// vector_sweep_checker
//
// Sequential response checker for combinational test modules. It drives every
// input vector 0 .. 2**A_WIDTH-1 onto the DUT. For each vector it fetches the
// expected output over a request/valid handshake. It compares the sampled DUT
// output under a per-bit care mask. It counts failing vectors and records the
// first failing vector.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start after reset
// APPLY   | dut_a held; settle counting and expectation fetch in progress
// COMPARE | single cycle: sample dut_y, compare, advance or finish
// DONE    | results held; start reruns the sweep
//
// Ports
//   clk              rising-edge clock
//   resetn           synchronous active-low reset
//   start            begin sweep (accepted in IDLE and DONE only)
//   busy / done      sweep in progress / finished (done held until next start)
//   pass             err_count == 0, meaningful while done = 1
//   dut_a            stimulus to DUT input
//   dut_y            DUT output, combinational from dut_a
//   exp_req/exp_idx  expectation request and the vector index it refers to
//   exp_valid        expectation data valid (ignored while exp_req = 0)
//   exp_value        expected DUT output
//   exp_mask         1 = bit must match, 0 = don't care
//   err_count        number of failing vectors
//   first_err_*      valid flag, index and masked XOR of the first failure
// ---------------------------------------------------------------------------
module vector_sweep_checker #(
  parameter int A_WIDTH = 4,
  parameter int Y_WIDTH = 16,
  parameter int SETTLE  = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [A_WIDTH-1:0] dut_a,
  input  logic [Y_WIDTH-1:0] dut_y,
  output logic               exp_req,
  output logic [A_WIDTH-1:0] exp_idx,
  input  logic               exp_valid,
  input  logic [Y_WIDTH-1:0] exp_value,
  input  logic [Y_WIDTH-1:0] exp_mask,
  output logic [A_WIDTH:0]   err_count,
  output logic               first_err_valid,
  output logic [A_WIDTH-1:0] first_err_idx,
  output logic [Y_WIDTH-1:0] first_err_diff
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0]         SETTLE_C = 4'(SETTLE);
  localparam logic [A_WIDTH-1:0] IDX_ONE  = {{(A_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [A_WIDTH:0]   ERR_ONE  = {{A_WIDTH{1'b0}}, 1'b1};

  state_t             state, state_nxt;

  logic               busy_nxt, done_nxt, pass_nxt;
  logic [A_WIDTH-1:0] dut_a_nxt, exp_idx_nxt;
  logic               exp_req_nxt;
  logic [A_WIDTH:0]   err_count_nxt;
  logic               first_err_valid_nxt;
  logic [A_WIDTH-1:0] first_err_idx_nxt;
  logic [Y_WIDTH-1:0] first_err_diff_nxt;

  logic [3:0]         settle_cnt, settle_cnt_nxt;
  logic               exp_cap, exp_cap_nxt;
  logic [Y_WIDTH-1:0] exp_value_q, exp_value_q_nxt;
  logic [Y_WIDTH-1:0] exp_mask_q, exp_mask_q_nxt;

  logic               handshake;
  logic [3:0]         settle_inc;
  logic [Y_WIDTH-1:0] diff;

  assign handshake  = exp_req & exp_valid;
  // The counter saturates at SETTLE; reaching SETTLE on this edge means the
  // input will have been held SETTLE cycles by the time COMPARE samples.
  assign settle_inc = (settle_cnt < SETTLE_C) ? settle_cnt + 4'd1 : settle_cnt;
  assign diff       = (dut_y ^ exp_value_q) & exp_mask_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      dut_a           <= '0;
      exp_idx         <= '0;
      exp_req         <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_diff  <= '0;
      settle_cnt      <= '0;
      exp_cap         <= 1'b0;
      exp_value_q     <= '0;
      exp_mask_q      <= '0;
    end else begin
      state           <= state_nxt;
      busy            <= busy_nxt;
      done            <= done_nxt;
      pass            <= pass_nxt;
      dut_a           <= dut_a_nxt;
      exp_idx         <= exp_idx_nxt;
      exp_req         <= exp_req_nxt;
      err_count       <= err_count_nxt;
      first_err_valid <= first_err_valid_nxt;
      first_err_idx   <= first_err_idx_nxt;
      first_err_diff  <= first_err_diff_nxt;
      settle_cnt      <= settle_cnt_nxt;
      exp_cap         <= exp_cap_nxt;
      exp_value_q     <= exp_value_q_nxt;
      exp_mask_q      <= exp_mask_q_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    busy_nxt            = busy;
    done_nxt            = done;
    pass_nxt            = pass;
    dut_a_nxt           = dut_a;
    exp_idx_nxt         = exp_idx;
    exp_req_nxt         = exp_req;
    err_count_nxt       = err_count;
    first_err_valid_nxt = first_err_valid;
    first_err_idx_nxt   = first_err_idx;
    first_err_diff_nxt  = first_err_diff;
    settle_cnt_nxt      = settle_cnt;
    exp_cap_nxt         = exp_cap;
    exp_value_q_nxt     = exp_value_q;
    exp_mask_q_nxt      = exp_mask_q;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt           = APPLY;
          busy_nxt            = 1'b1;
          done_nxt            = 1'b0;
          pass_nxt            = 1'b0;
          dut_a_nxt           = '0;
          exp_idx_nxt         = '0;
          exp_req_nxt         = 1'b1;
          err_count_nxt       = '0;
          first_err_valid_nxt = 1'b0;
          first_err_idx_nxt   = '0;
          first_err_diff_nxt  = '0;
          settle_cnt_nxt      = '0;
          exp_cap_nxt         = 1'b0;
        end
      end

      APPLY: begin
        settle_cnt_nxt = settle_inc;
        if (handshake) begin
          exp_value_q_nxt = exp_value;
          exp_mask_q_nxt  = exp_mask;
          exp_cap_nxt     = 1'b1;
          exp_req_nxt     = 1'b0;
        end
        // Settling and the fetch run in parallel; whichever finishes last
        // releases the vector to COMPARE.
        if ((settle_inc == SETTLE_C) && (exp_cap || handshake)) begin
          state_nxt = COMPARE;
        end
      end

      COMPARE: begin
        if (diff != '0) begin
          err_count_nxt = err_count + ERR_ONE;
          if (!first_err_valid) begin
            first_err_valid_nxt = 1'b1;
            first_err_idx_nxt   = dut_a;
            first_err_diff_nxt  = diff;
          end
        end
        if (&dut_a) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (err_count_nxt == '0);
        end else begin
          state_nxt      = APPLY;
          dut_a_nxt      = dut_a + IDX_ONE;
          exp_idx_nxt    = dut_a + IDX_ONE;
          exp_req_nxt    = 1'b1;
          settle_cnt_nxt = '0;
          exp_cap_nxt    = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vector_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_vector_sweep_checker
//
// Bench for vector_sweep_checker with A_WIDTH=2, Y_WIDTH=4, SETTLE=1 and a
// DUT model y = {2'b00, a}. An expectation source answers each request after
// a configurable latency and presents random junk while no request is open.
// The expected timeline and the expected results are derived arithmetically
// from the expectation table and the latency.
// ---------------------------------------------------------------------------
module tb_vector_sweep_checker;

  localparam int AW = 2;
  localparam int YW = 4;
  localparam int ST = 1;
  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass;
  logic [AW-1:0] dut_a, exp_idx;
  logic [YW-1:0] dut_y;
  logic          exp_req;
  logic          exp_valid;
  logic [YW-1:0] exp_value, exp_mask;
  logic [AW:0]   err_count;
  logic          first_err_valid;
  logic [AW-1:0] first_err_idx;
  logic [YW-1:0] first_err_diff;

  vector_sweep_checker #(.A_WIDTH(AW), .Y_WIDTH(YW), .SETTLE(ST)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .dut_a           (dut_a),
    .dut_y           (dut_y),
    .exp_req         (exp_req),
    .exp_idx         (exp_idx),
    .exp_valid       (exp_valid),
    .exp_value       (exp_value),
    .exp_mask        (exp_mask),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_idx   (first_err_idx),
    .first_err_diff  (first_err_diff)
  );

  assign dut_y = {2'b00, dut_a};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // expectation table and model results
  logic [YW-1:0] exp_tab [NV];
  logic [YW-1:0] mask_tab[NV];
  int            lat_cur = 0;
  int            apply_len = 1;
  int            run_t = 0;
  int            s_edge = 0;
  bit            run_active = 1'b0;
  int            m_err;
  bit            m_fv;
  int            m_fi;
  logic [YW-1:0] m_fd;

  task automatic set_exact();
    for (int k = 0; k < NV; k++) begin
      exp_tab[k]  = 4'(k);
      mask_tab[k] = 4'hF;
    end
  endtask

  task automatic compute_model();
    logic [YW-1:0] d;
    m_err = 0; m_fv = 1'b0; m_fi = 0; m_fd = '0;
    for (int k = 0; k < NV; k++) begin
      d = (4'(k) ^ exp_tab[k]) & mask_tab[k];
      if (d != '0) begin
        m_err++;
        if (!m_fv) begin
          m_fv = 1'b1; m_fi = k; m_fd = d;
        end
      end
    end
    apply_len = (lat_cur + 1 > ST) ? lat_cur + 1 : ST;
    run_t     = NV * (apply_len + 1);
  endtask

  // expectation source: answers exactly lat_cur cycles after exp_req rises
  initial begin
    int age;
    bit prev;
    age = 0; prev = 1'b0;
    exp_valid = 1'b0; exp_value = '0; exp_mask = '0;
    forever begin
      @(posedge clk); #1;
      if (exp_req) age = prev ? age + 1 : 0;
      else         age = 0;
      prev = exp_req;
      if (exp_req) begin
        exp_valid = (age == lat_cur);
        exp_value = exp_valid ? exp_tab[exp_idx]  : 4'($urandom);
        exp_mask  = exp_valid ? mask_tab[exp_idx] : 4'($urandom);
      end else begin
        exp_valid = 1'($urandom);
        exp_value = 4'($urandom);
        exp_mask  = 4'($urandom);
      end
    end
  end

  // per-cycle timeline check against the arithmetic model
  initial begin
    int r, k, o;
    forever begin
      @(posedge clk); #2;
      if (run_active) begin
        r = cyc - s_edge;
        if (r >= 0 && r < run_t) begin
          k = r / (apply_len + 1);
          o = r % (apply_len + 1);
          chk("busy_run", 32'(busy), 1);
          chk("done_run", 32'(done), 0);
          chk("dut_a_run", 32'(dut_a), k);
          chk("exp_idx_run", 32'(exp_idx), k);
          chk("exp_req_run", 32'(exp_req), 32'(o < apply_len && o <= lat_cur));
          if (r == 0) begin
            chk("err_clear", 32'(err_count), 0);
            chk("fv_clear", 32'(first_err_valid), 0);
            chk("pass_clear", 32'(pass), 0);
          end
        end else if (r >= run_t) begin
          chk("busy_done", 32'(busy), 0);
          chk("done_done", 32'(done), 1);
          chk("dut_a_done", 32'(dut_a), NV - 1);
          chk("exp_req_done", 32'(exp_req), 0);
          chk("pass_done", 32'(pass), 32'(m_err == 0));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_dut_a"}, 32'(dut_a), 0);
    chk({tag, "_exp_req"}, 32'(exp_req), 0);
    chk({tag, "_exp_idx"}, 32'(exp_idx), 0);
    chk({tag, "_err"}, 32'(err_count), 0);
    chk({tag, "_fv"}, 32'(first_err_valid), 0);
    chk({tag, "_fi"}, 32'(first_err_idx), 0);
    chk({tag, "_fd"}, 32'(first_err_diff), 0);
  endtask

  task automatic run_sweep(input int lat, input bit poke, input int len_lit);
    bit got;
    lat_cur = lat;
    compute_model();
    @(posedge clk); #1;
    start = 1'b1;
    s_edge = cyc + 1;
    run_active = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      start = poke ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!got) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("sweep_len", cyc - s_edge, run_t);
      if (len_lit >= 0) chk("sweep_len_lit", cyc - s_edge, len_lit);
      chk("err_count", 32'(err_count), m_err);
      chk("pass", 32'(pass), 32'(m_err == 0));
      chk("first_err_valid", 32'(first_err_valid), 32'(m_fv));
      chk("first_err_idx", 32'(first_err_idx), m_fi);
      chk("first_err_diff", 32'(first_err_diff), 32'(m_fd));
    end
    repeat (2) @(posedge clk);
    #1;
    run_active = 1'b0;
  endtask

  task automatic reset_mid(input int lat);
    bit got;
    set_exact();
    lat_cur = lat;
    compute_model();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (dut_a == 2'd2 && exp_req) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("reach_idx2", 32'(got), 1);
    // reset with a concurrent start: reset must win
    resetn = 1'b0;
    start  = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midrst");
    start  = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_rst", 32'(busy), 0);
    chk("req_after_rst", 32'(exp_req), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_exact();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    resetn = 1'b1;

    // exact model
    set_exact();
    run_sweep(0, 1'b0, 8);
    chk("lit_exact_err", 32'(err_count), 0);
    chk("lit_exact_pass", 32'(pass), 1);
    chk("lit_exact_fv", 32'(first_err_valid), 0);

    // wrong expectation at idx 2 (restart from DONE)
    exp_tab[2] = 4'b0110;
    run_sweep(0, 1'b0, 8);
    chk("lit_one_err", 32'(err_count), 1);
    chk("lit_one_pass", 32'(pass), 0);
    chk("lit_one_fi", 32'(first_err_idx), 2);
    chk("lit_one_fd", 32'(first_err_diff), 32'(4'b0100));

    // don't-care bit hides the mismatch
    mask_tab[2] = 4'b1011;
    run_sweep(0, 1'b0, 8);
    chk("lit_mask_err", 32'(err_count), 0);
    chk("lit_mask_pass", 32'(pass), 1);

    // two failures, first not overwritten
    set_exact();
    exp_tab[1] = 4'b1001;
    exp_tab[3] = 4'b0111;
    run_sweep(0, 1'b1, 8);
    chk("lit_two_err", 32'(err_count), 2);
    chk("lit_two_fi", 32'(first_err_idx), 1);

    // expectation latency of 3 cycles, start pokes while busy
    set_exact();
    run_sweep(3, 1'b1, 20);
    chk("lit_lat_err", 32'(err_count), 0);
    chk("lit_lat_pass", 32'(pass), 1);

    // reset mid-sweep and mid-handshake, then a clean sweep from IDLE
    reset_mid(3);
    set_exact();
    run_sweep(0, 1'b0, 8);

    // randomized tables and latencies
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < NV; k++) begin
        exp_tab[k]  = ($urandom_range(0, 1) == 0) ? 4'(k) : 4'($urandom);
        mask_tab[k] = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      end
      run_sweep(int'($urandom_range(0, 4)), 1'($urandom), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
